// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n}, arbiter
// FSM states and default bus widths.
package sdram_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int BANK_W_DEF = 2;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_NOP   = 4'b0111;
  localparam cmd_t CMD_PREC  = 4'b0010;
  localparam cmd_t CMD_AREF  = 4'b0001;
  localparam cmd_t CMD_ACT   = 4'b0011;
  localparam cmd_t CMD_WRITE = 4'b0100;
  localparam cmd_t CMD_READ  = 4'b0101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_arbiter.sv
// Fixed-priority SDRAM command arbiter (refresh > write > read); grant one cycle after ARBIT
// samples a request, held until the owner's *_end pulse (no preemption); pins muxed from state.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BANK_W = BANK_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BANK_W-1:0] aref_bank,
  input  logic [ADDR_W-1:0] aref_addr,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr
);

  arb_state_t state, state_nxt;
  cmd_t       cmd_mux;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (init_end) state_nxt = ST_ARBIT;
      ST_ARBIT: begin
        if (aref_req)    state_nxt = ST_AREF;
        else if (wr_req) state_nxt = ST_WRITE;
        else if (rd_req) state_nxt = ST_READ;
      end
      ST_AREF:  if (aref_end) state_nxt = ST_ARBIT;
      ST_WRITE: if (wr_end)   state_nxt = ST_ARBIT;
      ST_READ:  if (rd_end)   state_nxt = ST_ARBIT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ARBIT drives a NOP with all-ones bank/address so the bus is never left floating between grants.
  always_comb begin
    aref_en    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    cmd_mux    = CMD_NOP;
    sdram_ba   = '1;
    sdram_addr = '1;
    case (state)
      ST_IDLE: begin
        cmd_mux    = init_cmd;
        sdram_ba   = init_bank;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        aref_en    = 1'b1;
        cmd_mux    = aref_cmd;
        sdram_ba   = aref_bank;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        wr_en      = 1'b1;
        cmd_mux    = wr_cmd;
        sdram_ba   = wr_bank;
        sdram_addr = wr_addr;
      end
      ST_READ: begin
        rd_en      = 1'b1;
        cmd_mux    = rd_cmd;
        sdram_ba   = rd_bank;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Cycle-stepped bench for sdram_arbiter: vector table plus scoreboard of expected grant/pin state.
module tb_sdram_arbiter;

  localparam int AW = 13;
  localparam int BW = 2;

  localparam int S_IDLE = 0;
  localparam int S_ARB  = 1;
  localparam int S_AREF = 2;
  localparam int S_WR   = 3;
  localparam int S_RD   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic [3:0]    init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [BW-1:0] init_bank, aref_bank, wr_bank, rd_bank;
  logic [AW-1:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic          aref_en, wr_en, rd_en;
  logic          sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BW-1:0] sdram_ba;
  logic [AW-1:0] sdram_addr;

  sdram_arbiter #(.ADDR_W(AW), .BANK_W(BW)) dut (
    .clk(clk), .rst(rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_bank(aref_bank), .aref_addr(aref_addr), .aref_en(aref_en),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_en(rd_en),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr)
  );

  typedef struct {
    logic rst, init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
    int   exp_st;
  } vec_t;

  typedef struct {
    int            st;
    logic [2:0]    grant;
    logic [3:0]    cmd;
    logic [BW-1:0] ba;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic r, logic ie, logic aq, logic ae, logic wq, logic we,
                              logic rq, logic re, int st);
    vec_t v;
    v.rst = r; v.init_end = ie; v.aref_req = aq; v.aref_end = ae;
    v.wr_req = wq; v.wr_end = we; v.rd_req = rq; v.rd_end = re; v.exp_st = st;
    return v;
  endfunction

  // Expected pins and grants for a given arbiter state, using the bus values currently driven.
  function automatic exp_t model(int st);
    exp_t e;
    e.st = st;
    case (st)
      S_IDLE:  begin e.grant = 3'b000; e.cmd = init_cmd; e.ba = init_bank; e.addr = init_addr; end
      S_AREF:  begin e.grant = 3'b100; e.cmd = aref_cmd; e.ba = aref_bank; e.addr = aref_addr; end
      S_WR:    begin e.grant = 3'b010; e.cmd = wr_cmd;   e.ba = wr_bank;   e.addr = wr_addr;   end
      S_RD:    begin e.grant = 3'b001; e.cmd = rd_cmd;   e.ba = rd_bank;   e.addr = rd_addr;   end
      default: begin e.grant = 3'b000; e.cmd = 4'b0111;  e.ba = 2'b11;     e.addr = 13'h1fff;  end
    endcase
    return e;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s step %0d: got %h, want %h", name, idx, act, req);
  endtask

  task automatic compare_outputs(int idx, exp_t e);
    check("grant", idx, {29'd0, aref_en, wr_en, rd_en}, {29'd0, e.grant});
    check("cmd",   idx, {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'd0, e.cmd});
    check("ba",    idx, {30'd0, sdram_ba}, {30'd0, e.ba});
    check("addr",  idx, {19'd0, sdram_addr}, {19'd0, e.addr});
  endtask

  task automatic step(int idx, vec_t v);
    exp_t e;
    rst = v.rst; init_end = v.init_end;
    aref_req = v.aref_req; aref_end = v.aref_end;
    wr_req = v.wr_req; wr_end = v.wr_end;
    rd_req = v.rd_req; rd_end = v.rd_end;
    sb.push_back(model(v.exp_st));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard step %0d: got empty queue, want one entry", idx);
      n_total++;
    end else begin
      e = sb.pop_front();
      compare_outputs(idx, e);
    end
  endtask

  initial begin
    init_cmd = 4'b0010; init_bank = 2'b10; init_addr = 13'h0400;
    aref_cmd = 4'b0001; aref_bank = 2'b00; aref_addr = 13'h0123;
    wr_cmd   = 4'b0100; wr_bank   = 2'b10; wr_addr   = 13'h0abc;
    rd_cmd   = 4'b0101; rd_bank   = 2'b01; rd_addr   = 13'h0040;

    //          rst ie aq ae wq we rq re  state after edge
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, S_IDLE));  // reset
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));  // wait for init
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, S_ARB));   // init done -> NOP/1fff
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, S_AREF));  // all three -> refresh wins
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, S_AREF));  // held, no preemption
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, S_ARB));   // aref_end
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, S_WR));    // write beats read
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, S_WR));    // aref_req during write
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, S_ARB));   // wr_end
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, S_AREF));  // pending refresh beats read
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, S_ARB));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, S_RD));    // read finally granted
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, S_RD));    // stray wr_end
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, S_RD));    // stray aref_end
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, S_RD));    // init_end ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, S_ARB));   // rd_end
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, S_ARB));   // idle arbitration
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, S_WR));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, S_WR));    // stray rd_end
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, S_ARB));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, S_AREF));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, S_IDLE));  // reset aborts refresh
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, S_IDLE));  // requests ignored in IDLE
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, S_ARB));   // re-enter ARBIT
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, S_AREF));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, S_ARB));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, S_IDLE));  // reset from ARBIT with write pending

    for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

    // Read held across many cycles with a write waiting: exactly one ARBIT gap, then write.
    step(100, mk(0, 1, 0, 0, 0, 0, 1, 0, S_ARB));
    step(101, mk(0, 0, 0, 0, 0, 0, 1, 0, S_RD));
    for (int k = 0; k < 5; k++) step(102 + k, mk(0, 0, 0, 0, 1, 0, 0, 0, S_RD));
    step(107, mk(0, 0, 0, 0, 1, 0, 0, 1, S_ARB));
    step(108, mk(0, 0, 0, 0, 1, 0, 0, 0, S_WR));
    step(109, mk(0, 0, 0, 0, 0, 1, 1, 0, S_ARB));
    step(110, mk(0, 0, 0, 0, 0, 0, 1, 0, S_RD));

    // Pins follow the read bus combinationally while READ is held.
    rd_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      rd_cmd  = 4'($urandom_range(0, 15));
      rd_bank = 2'($urandom_range(0, 3));
      rd_addr = 13'($urandom_range(0, 8191));
      #2;
      e = model(S_RD);
      compare_outputs(200 + k, e);
      @(posedge clk);
      #1;
    end
    rd_cmd = 4'b0101; rd_bank = 2'b01; rd_addr = 13'h0040;
    #1;
    compare_outputs(210, model(S_RD));

    step(211, mk(0, 0, 0, 0, 0, 0, 0, 1, S_ARB));

    if (sb.size() != 0) begin
      $display("FAIL scoreboard drain: got %0d entries left, want 0", sb.size());
      n_total++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, want finish before 200000");
    $fatal(1);
  end

endmodule
